// File: rtl/lc3b_types.sv
// Shared LC-3b types: bus words, byte masks and the memory-arbiter state/port enums.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVE_A = 2'b01,
    SERVE_B = 2'b10,
    RESP    = 2'b11
  } mem_arb_state;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } mem_arb_port;

  // Round-robin pick: on a tie the port that did not win last time goes next.
  function automatic mem_arb_port arb_pick(input logic req_a, input logic req_b,
                                           input mem_arb_port last_grant);
    mem_arb_port pick;
    pick = GRANT_A;
    if (req_a && req_b) begin
      if (last_grant == GRANT_A) pick = GRANT_B;
      else                       pick = GRANT_A;
    end else if (req_b) begin
      pick = GRANT_B;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (instruction A / data B) arbiter in front of a single physical memory.
// One access in flight at a time; requests are latched on grant so the memory
// sees stable controls regardless of what the requesters do while it works.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int PMEM_WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          mem_read_a,
  input  lc3b_word      mem_address_a,
  output logic          mem_resp_a,
  output lc3b_word      mem_rdata_a,

  input  logic          mem_read_b,
  input  logic          mem_write_b,
  input  lc3b_word      mem_address_b,
  input  lc3b_word      mem_wdata_b,
  input  lc3b_mem_wmask mem_wmask_b,
  output logic          mem_resp_b,
  output lc3b_word      mem_rdata_b,

  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_word      pmem_address,
  output lc3b_word      pmem_wdata,
  output lc3b_mem_wmask pmem_wmask,
  input  logic          pmem_resp,
  input  lc3b_word      pmem_rdata
);

  mem_arb_state          r_state;
  mem_arb_port           r_last_grant;
  mem_arb_port           r_cur_grant;
  logic                  r_pmem_read;
  logic                  r_pmem_write;
  logic                  r_resp_a;
  logic                  r_resp_b;
  lc3b_word              r_addr;
  lc3b_word              r_wdata;
  lc3b_mem_wmask         r_wmask;
  logic [PMEM_WIDTH-1:0] r_rdata;

  logic                  w_req_a;
  logic                  w_req_b;
  logic                  w_any_req;
  logic                  w_serving;
  mem_arb_port           w_pick;

  // B asserting read and write together is a write, so any B activity is one request.
  assign w_req_a   = mem_read_a;
  assign w_req_b   = mem_read_b | mem_write_b;
  assign w_any_req = w_req_a | w_req_b;
  assign w_serving = (r_state == SERVE_A) || (r_state == SERVE_B);
  assign w_pick    = arb_pick(w_req_a, w_req_b, r_last_grant);

  // Arbitration FSM with registered memory strobes and completion pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_A;
      r_cur_grant  <= GRANT_A;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
      r_resp_a     <= 1'b0;
      r_resp_b     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_resp_a <= 1'b0;
          r_resp_b <= 1'b0;
          if (w_any_req) begin
            r_cur_grant <= w_pick;
            if (w_pick == GRANT_B) begin
              r_state      <= SERVE_B;
              r_pmem_write <= mem_write_b;
              r_pmem_read  <= ~mem_write_b;
            end else begin
              r_state      <= SERVE_A;
              r_pmem_write <= 1'b0;
              r_pmem_read  <= 1'b1;
            end
          end
        end
        SERVE_A, SERVE_B: begin
          if (pmem_resp) begin
            r_state      <= RESP;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_last_grant <= r_cur_grant;
            r_resp_a     <= (r_cur_grant == GRANT_A);
            r_resp_b     <= (r_cur_grant == GRANT_B);
          end
        end
        RESP: begin
          // Requests are not looked at here; the next grant happens from IDLE.
          r_state  <= IDLE;
          r_resp_a <= 1'b0;
          r_resp_b <= 1'b0;
        end
        default: begin
          r_state      <= IDLE;
          r_pmem_read  <= 1'b0;
          r_pmem_write <= 1'b0;
          r_resp_a     <= 1'b0;
          r_resp_b     <= 1'b0;
        end
      endcase
    end
  end

  // Latch the winning request's address/data/mask at grant time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if ((r_state == IDLE) && w_any_req) begin
      if (w_pick == GRANT_B) begin
        r_addr  <= mem_address_b;
        r_wdata <= mem_wdata_b;
        r_wmask <= mem_wmask_b;
      end else begin
        r_addr  <= mem_address_a;
        r_wdata <= '0;
        r_wmask <= '0;
      end
    end
  end

  // Capture memory read data on completion; both ports see the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (w_serving && pmem_resp) begin
      r_rdata <= pmem_rdata;
    end
  end

  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;
  assign pmem_wmask   = r_wmask;

  assign mem_resp_a   = r_resp_a;
  assign mem_resp_b   = r_resp_b;
  assign mem_rdata_a  = r_rdata;
  assign mem_rdata_b  = r_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by randomized
// traffic against a transaction-level model (round-robin winner, word memory).
module tb_mem_arbiter;
  import lc3b_types::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_read_a;
  lc3b_word      mem_address_a;
  logic          mem_resp_a;
  lc3b_word      mem_rdata_a;
  logic          mem_read_b;
  logic          mem_write_b;
  lc3b_word      mem_address_b;
  lc3b_word      mem_wdata_b;
  lc3b_mem_wmask mem_wmask_b;
  logic          mem_resp_b;
  lc3b_word      mem_rdata_b;
  logic          pmem_read;
  logic          pmem_write;
  lc3b_word      pmem_address;
  lc3b_word      pmem_wdata;
  lc3b_mem_wmask pmem_wmask;
  logic          pmem_resp;
  lc3b_word      pmem_rdata;

  mem_arbiter #(.PMEM_WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read_a   (mem_read_a),
    .mem_address_a(mem_address_a),
    .mem_resp_a   (mem_resp_a),
    .mem_rdata_a  (mem_rdata_a),
    .mem_read_b   (mem_read_b),
    .mem_write_b  (mem_write_b),
    .mem_address_b(mem_address_b),
    .mem_wdata_b  (mem_wdata_b),
    .mem_wmask_b  (mem_wmask_b),
    .mem_resp_b   (mem_resp_b),
    .mem_rdata_b  (mem_rdata_b),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_wmask   (pmem_wmask),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit            last_b;        // 1 when B won the most recent completed access
  bit            a_pend;
  lc3b_word      a_addr;
  bit            b_pend;
  int            b_kind;        // 0 read, 1 write, 2 read+write (acts as write)
  lc3b_word      b_addr;
  lc3b_word      b_wdata;
  logic [1:0]    b_wmask;
  lc3b_word      mem_model [lc3b_word];
  bit            wb;

  function automatic lc3b_word mem_rd(input lc3b_word a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 16'hC3A5;
  endfunction

  task automatic mem_wr(input lc3b_word a, input lc3b_word d, input logic [1:0] m);
    lc3b_word cur;
    cur = mem_rd(a);
    if (m[1]) cur[15:8] = d[15:8];
    if (m[0]) cur[7:0]  = d[7:0];
    mem_model[a] = cur;
  endtask

  task automatic gen_a(input lc3b_word addr);
    a_pend = 1'b1;
    a_addr = addr;
  endtask

  task automatic gen_b(input int kind, input lc3b_word addr, input lc3b_word wdata,
                       input logic [1:0] wmask);
    b_pend  = 1'b1;
    b_kind  = kind;
    b_addr  = addr;
    b_wdata = wdata;
    b_wmask = wmask;
  endtask

  task automatic rand_a();
    gen_a(16'h0100 + lc3b_word'($urandom_range(0, 15)));
  endtask

  task automatic rand_b();
    gen_b($urandom_range(0, 2), 16'h0100 + lc3b_word'($urandom_range(0, 15)),
          lc3b_word'($urandom), 2'($urandom_range(0, 3)));
  endtask

  task automatic drive_inputs();
    mem_read_a    = a_pend;
    mem_address_a = a_addr;
    mem_read_b    = b_pend && (b_kind != 1);
    mem_write_b   = b_pend && (b_kind != 0);
    mem_address_b = b_addr;
    mem_wdata_b   = b_wdata;
    mem_wmask_b   = b_wmask;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    pmem_resp = 1'b0;
    a_pend    = 1'b0;
    b_pend    = 1'b0;
    drive_inputs();
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    last_b = 1'b0;
  endtask

  // One arbitrated access, called at a negedge with requests already driven.
  // regen: 0 = winner drops, 1 = winner maybe re-requests, 2 = winner re-requests.
  task automatic run_txn(input int lat, input bit scramble, input int regen, output bit won_b);
    bit         exp_b;
    bit         exp_w;
    lc3b_word   ea;
    lc3b_word   ed;
    logic [1:0] em;
    lc3b_word   rd;
    int         waited;

    exp_b = (a_pend && b_pend) ? !last_b : b_pend;
    if (exp_b) begin
      exp_w = (b_kind != 0);
      ea = b_addr; ed = b_wdata; em = b_wmask;
    end else begin
      exp_w = 1'b0;
      ea = a_addr; ed = '0; em = '0;
    end
    won_b = exp_b;

    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(pmem_read || pmem_write) && waited < 20);
    check_val("pmem_req_latency", waited, 1);
    if (!(pmem_read || pmem_write)) return;

    check_val("pmem_read", pmem_read, !exp_w);
    check_val("pmem_write", pmem_write, exp_w);
    check_val("pmem_address", pmem_address, ea);
    if (exp_w) begin
      check_val("pmem_wdata", pmem_wdata, ed);
      check_val("pmem_wmask", pmem_wmask, em);
    end

    for (int i = 0; i < lat; i++) begin
      if (scramble) begin
        if (exp_b) begin
          mem_address_b = lc3b_word'($urandom);
          mem_wdata_b   = lc3b_word'($urandom);
          mem_wmask_b   = 2'($urandom_range(0, 3));
        end else begin
          mem_address_a = lc3b_word'($urandom);
        end
      end
      @(negedge clk);
      check_val("hold_read", pmem_read, !exp_w);
      check_val("hold_write", pmem_write, exp_w);
      check_val("hold_address", pmem_address, ea);
      if (exp_w) begin
        check_val("hold_wdata", pmem_wdata, ed);
        check_val("hold_wmask", pmem_wmask, em);
      end
      check_val("no_early_resp", {mem_resp_a, mem_resp_b}, 2'b00);
    end

    rd = exp_w ? lc3b_word'($urandom) : mem_rd(ea);
    pmem_rdata = rd;
    pmem_resp  = 1'b1;
    @(negedge clk);
    pmem_resp  = 1'b0;
    pmem_rdata = lc3b_word'($urandom);
    won_b = mem_resp_b;
    check_val("resp_a", mem_resp_a, !exp_b);
    check_val("resp_b", mem_resp_b, exp_b);
    check_val("strobes_drop", {pmem_read, pmem_write}, 2'b00);
    if (!exp_w) begin
      check_val("rdata_a", mem_rdata_a, rd);
      check_val("rdata_b", mem_rdata_b, rd);
    end else begin
      mem_wr(ea, ed, em);
    end

    last_b = exp_b;
    if (exp_b) b_pend = 1'b0;
    else       a_pend = 1'b0;
    if (regen == 2 || (regen == 1 && $urandom_range(0, 1) == 1)) begin
      if (exp_b) rand_b();
      else       rand_a();
    end
    drive_inputs();
    @(negedge clk);
    check_val("resp_one_cycle", {mem_resp_a, mem_resp_b}, 2'b00);
  endtask

  // Mutual exclusion of memory strobes and of completion pulses, every cycle.
  always @(negedge clk) begin
    if (mon_en && rst_n)
      check_val("exclusive", {pmem_read & pmem_write, mem_resp_a & mem_resp_b}, 2'b00);
  end

  initial begin
    rst_n      = 1'b0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    a_pend = 1'b0; a_addr = '0;
    b_pend = 1'b0; b_kind = 0; b_addr = '0; b_wdata = '0; b_wmask = '0;
    last_b = 1'b0;
    drive_inputs();

    // Reset values
    repeat (2) @(negedge clk);
    check_val("rst_strobes", {pmem_read, pmem_write}, 2'b00);
    check_val("rst_resp", {mem_resp_a, mem_resp_b}, 2'b00);
    check_val("rst_rdata", mem_rdata_a, 16'h0000);
    check_val("rst_addr", pmem_address, 16'h0000);
    check_val("rst_wdata", pmem_wdata, 16'h0000);
    check_val("rst_wmask", pmem_wmask, 2'b00);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Idle with no requests
    repeat (3) begin
      @(negedge clk);
      check_val("idle_quiet", {pmem_read, pmem_write, mem_resp_a, mem_resp_b}, 4'h0);
    end

    // A-only read
    mem_model[16'h0040] = 16'h1234;
    gen_a(16'h0040);
    drive_inputs();
    run_txn(3, 1'b0, 0, wb);
    check_val("a_read_rdata", mem_rdata_a, 16'h1234);

    // B masked write, requester scrambles inputs while being served, then read back
    gen_b(1, 16'h2001, 16'hABCD, 2'b10);
    drive_inputs();
    run_txn(4, 1'b1, 0, wb);
    gen_b(0, 16'h2001, 16'h0000, 2'b00);
    drive_inputs();
    run_txn(2, 1'b1, 0, wb);
    check_val("b_mask_readback", mem_rdata_b, {8'hAB, 8'h01 ^ 8'hA5});

    // Tie alternation from reset: B, A, B
    do_reset();
    gen_a(16'h0300);
    gen_b(0, 16'h0400, 16'h0000, 2'b00);
    drive_inputs();
    run_txn(1, 1'b0, 2, wb);
    check_val("tie1_winner_b", wb, 1'b1);
    run_txn(0, 1'b0, 2, wb);
    check_val("tie2_winner_a", wb, 1'b0);
    run_txn(2, 1'b0, 0, wb);
    check_val("tie3_winner_b", wb, 1'b1);
    run_txn(0, 1'b0, 0, wb);

    // Read and write together on B acts as a write
    gen_b(2, 16'h0500, 16'h5A5A, 2'b11);
    drive_inputs();
    run_txn(1, 1'b0, 0, wb);
    gen_a(16'h0500);
    drive_inputs();
    run_txn(0, 1'b0, 0, wb);
    check_val("rw_both_readback", mem_rdata_a, 16'h5A5A);

    // Reset in the middle of an A read
    gen_a(16'h0077);
    drive_inputs();
    @(negedge clk);
    check_val("mid_rst_pre_read", pmem_read, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_async_read", {pmem_read, pmem_write}, 2'b00);
    check_val("mid_rst_no_resp", {mem_resp_a, mem_resp_b}, 2'b00);
    a_pend = 1'b0;
    drive_inputs();
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    last_b = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_val("post_rst_quiet", {pmem_read, pmem_write, mem_resp_a, mem_resp_b}, 4'h0);
    end
    gen_a(16'h0078);
    drive_inputs();
    run_txn(1, 1'b0, 0, wb);

    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      if (!a_pend && $urandom_range(0, 2) == 0) rand_a();
      if (!b_pend && $urandom_range(0, 2) == 0) rand_b();
      if (!a_pend && !b_pend) begin
        if ($urandom_range(0, 1) == 1) rand_a();
        else                           rand_b();
      end
      drive_inputs();
      run_txn($urandom_range(0, 4), 1'($urandom_range(0, 1)), 1, wb);
    end

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
